// File: rtl/rf_arb_pkg.sv
// Shared types, default widths and pointer helper for the register-file write arbiter.
// Optional hazard compare is enabled with RF_WRITE_ARBITER_HAZARD_EN.
package rf_arb_pkg;

  localparam int ADDR_W_DEF       = 5;
  localparam int DATA_W_DEF       = 32;
  localparam int DEPTH_DEF        = 4;
  localparam int STARVE_LIMIT_DEF = 8;
  localparam int REG_ZERO         = 0;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wr_req_t;

  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
    return (ptr + 1 >= depth) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Valid/ready write-request channel from the secondary (long-latency) unit.
// Used unchanged whether or not RF_WRITE_ARBITER_HAZARD_EN is defined.
interface rf_write_arbiter_if #(
  parameter int ADDRESS_WIDTH = rf_arb_pkg::ADDR_W_DEF,
  parameter int DATA_WIDTH    = rf_arb_pkg::DATA_W_DEF
);
  logic                     valid;
  logic                     ready;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0]    data;

  modport master (output valid, output addr, output data, input ready);
  modport slave  (input valid, input addr, input data, output ready);
endinterface

// File: rtl/rf_write_arbiter_fifo.sv
// Secondary-write FIFO (DEPTH entries, in-order drain); entry vector exported
// only when RF_WRITE_ARBITER_HAZARD_EN is defined.
module rf_wr_fifo
  import rf_arb_pkg::*;
#(
  parameter int DEPTH         = DEPTH_DEF,
  parameter int ADDRESS_WIDTH = ADDR_W_DEF,
  parameter int DATA_WIDTH    = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [ADDRESS_WIDTH-1:0] push_addr,
  input  logic [DATA_WIDTH-1:0]    push_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [ADDRESS_WIDTH-1:0] head_addr,
  output logic [DATA_WIDTH-1:0]    head_data
`ifdef RF_WRITE_ARBITER_HAZARD_EN
  ,
  output logic [DEPTH-1:0]                    ent_valid,
  output logic [DEPTH-1:0][ADDRESS_WIDTH-1:0] ent_addr
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    data;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_addr = mem[rd_ptr].addr;
  assign head_data = mem[rd_ptr].data;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= PW'(ptr_next(32'(wr_ptr), 32'(DEPTH)));
      if (do_pop)  rd_ptr <= PW'(ptr_next(32'(rd_ptr), 32'(DEPTH)));
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; validity is derived from the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= '{addr: push_addr, data: push_data};
  end

`ifdef RF_WRITE_ARBITER_HAZARD_EN
  always_comb begin
    ent_valid = '0;
    ent_addr  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_addr[i]  = mem[i].addr;
      ent_valid[i] = (CW'(PW'(i) - rd_ptr) < count);
    end
  end
`endif

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between pipeline writeback (priority) and a
// buffered secondary unit. Optional read-hazard outputs: RF_WRITE_ARBITER_HAZARD_EN.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ADDR_W_DEF,
  parameter int DATA_WIDTH    = DATA_W_DEF,
  parameter int DEPTH         = DEPTH_DEF,
  parameter int STARVE_LIMIT  = STARVE_LIMIT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_we,
  input  logic [ADDRESS_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0]    wb_data,
  rf_write_arbiter_if.slave        sec,
  output logic                     stall_req,
  output logic                     we3,
  output logic [ADDRESS_WIDTH-1:0] ad3,
  output logic [DATA_WIDTH-1:0]    wd3,
  output logic [$clog2(DEPTH):0]   pending_cnt
`ifdef RF_WRITE_ARBITER_HAZARD_EN
  ,
  input  logic [ADDRESS_WIDTH-1:0] rd_ad1,
  input  logic [ADDRESS_WIDTH-1:0] rd_ad2,
  output logic                     hazard1,
  output logic                     hazard2
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic                     fifo_full;
  logic                     fifo_empty;
  logic [CW-1:0]            fifo_count;
  logic [ADDRESS_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0]    head_data;
  logic                     wb_active;
  logic                     drain;
  logic                     push;
  logic [SW-1:0]            starve_cnt;
  logic                     stall_flag;
`ifdef RF_WRITE_ARBITER_HAZARD_EN
  logic [DEPTH-1:0]                    ent_valid;
  logic [DEPTH-1:0][ADDRESS_WIDTH-1:0] ent_addr;
`endif

  // A writeback to x0 is treated as an idle port cycle.
  assign wb_active = wb_we && (wb_addr != ADDRESS_WIDTH'(REG_ZERO));
  assign drain     = !rst && !wb_active && !fifo_empty;
  assign sec.ready = !rst && !fifo_full;
  assign push      = sec.valid && sec.ready && (sec.addr != ADDRESS_WIDTH'(REG_ZERO));

  rf_wr_fifo #(
    .DEPTH         (DEPTH),
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (drain),
    .push_addr (sec.addr),
    .push_data (sec.data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head_addr (head_addr),
    .head_data (head_data)
`ifdef RF_WRITE_ARBITER_HAZARD_EN
    ,
    .ent_valid (ent_valid),
    .ent_addr  (ent_addr)
`endif
  );

  always_comb begin
    we3 = 1'b0;
    ad3 = '0;
    wd3 = '0;
    if (!rst) begin
      if (wb_active) begin
        we3 = 1'b1;
        ad3 = wb_addr;
        wd3 = wb_data;
      end else if (!fifo_empty) begin
        we3 = 1'b1;
        ad3 = head_addr;
        wd3 = head_data;
      end
    end
  end

  assign pending_cnt = rst ? '0 : fifo_count;
  assign stall_req   = stall_flag && !rst;

  // Starvation tracking: the stall request rises one cycle after the head has
  // waited STARVE_LIMIT cycles and falls one cycle after it finally drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      stall_flag <= 1'b0;
    end else begin
      if (fifo_empty || drain)
        starve_cnt <= '0;
      else if (starve_cnt != SW'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 1'b1;

      if (drain)
        stall_flag <= 1'b0;
      else if (starve_cnt == SW'(STARVE_LIMIT))
        stall_flag <= 1'b1;
    end
  end

`ifdef RF_WRITE_ARBITER_HAZARD_EN
  always_comb begin
    hazard1 = 1'b0;
    hazard2 = 1'b0;
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_valid[i] && ent_addr[i] == rd_ad1 && rd_ad1 != ADDRESS_WIDTH'(REG_ZERO))
          hazard1 = 1'b1;
        if (ent_valid[i] && ent_addr[i] == rd_ad2 && rd_ad2 != ADDRESS_WIDTH'(REG_ZERO))
          hazard2 = 1'b1;
      end
    end
  end
`endif

`ifndef SYNTHESIS
  // The pipeline must hold off writeback while a stall is requested.
  stall_violation: assert property (@(posedge clk) disable iff (rst) !(stall_flag && wb_we));
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios plus a randomized run
// against a queue-based reference model (hazard checks when RF_WRITE_ARBITER_HAZARD_EN).
module tb_rf_write_arbiter;
  import rf_arb_pkg::*;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_we;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          stall_req;
  logic          we3;
  logic [AW-1:0] ad3;
  logic [DW-1:0] wd3;
  logic [CW-1:0] pending_cnt;
`ifdef RF_WRITE_ARBITER_HAZARD_EN
  logic [AW-1:0] rd_ad1;
  logic [AW-1:0] rd_ad2;
  logic          hazard1;
  logic          hazard2;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rf_write_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) sec ();

  rf_write_arbiter #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .DEPTH         (DEPTH),
    .STARVE_LIMIT  (LIMIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wb_we       (wb_we),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .sec         (sec.slave),
    .stall_req   (stall_req),
    .we3         (we3),
    .ad3         (ad3),
    .wd3         (wd3),
    .pending_cnt (pending_cnt)
`ifdef RF_WRITE_ARBITER_HAZARD_EN
    ,
    .rd_ad1      (rd_ad1),
    .rd_ad2      (rd_ad2),
    .hazard1     (hazard1),
    .hazard2     (hazard2)
`endif
  );

  task automatic drive(input logic r, input logic we, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic sv,
                       input logic [AW-1:0] sa, input logic [DW-1:0] sd);
    rst       = r;
    wb_we     = we;
    wb_addr   = wa;
    wb_data   = wd;
    sec.valid = sv;
    sec.addr  = sa;
    sec.data  = sd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
      next_cycle();
    end
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b1, 5'd4, 32'h1111, 1'b1, 5'd5, 32'h1234);
      @(negedge clk);
      total++;
      if (sec.ready !== 1'b0) begin bad++; $display("FAIL reset_ready c=%0d got=%b exp=0", c, sec.ready); end
      total++;
      if (we3 !== 1'b0 || ad3 !== '0 || wd3 !== '0) begin
        bad++; $display("FAIL reset_port c=%0d got=%b/%0h/%0h exp=0/0/0", c, we3, ad3, wd3);
      end
      total++;
      if (pending_cnt !== '0) begin bad++; $display("FAIL reset_pending c=%0d got=%0d exp=0", c, pending_cnt); end
      total++;
      if (stall_req !== 1'b0) begin bad++; $display("FAIL reset_stall c=%0d got=%b exp=0", c, stall_req); end
      next_cycle();
    end
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    @(negedge clk);
    total++;
    if (sec.ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%b exp=1", sec.ready); end
    next_cycle();
  endtask

  task automatic test_drain_latency();
    do_reset();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd5, 32'hDEADBEEF);
    @(negedge clk);
    total++;
    if (we3 !== 1'b0) begin bad++; $display("FAIL no_bypass got=%b exp=0", we3); end
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    @(negedge clk);
    total++;
    if (we3 !== 1'b1 || ad3 !== 5'd5 || wd3 !== 32'hDEADBEEF) begin
      bad++; $display("FAIL drain_write got=%b/%0d/%h exp=1/5/deadbeef", we3, ad3, wd3);
    end
    total++;
    if (pending_cnt !== CW'(1)) begin bad++; $display("FAIL drain_pending1 got=%0d exp=1", pending_cnt); end
    next_cycle();
    @(negedge clk);
    total++;
    if (pending_cnt !== '0 || we3 !== 1'b0) begin
      bad++; $display("FAIL drain_after got=%0d/%b exp=0/0", pending_cnt, we3);
    end
    next_cycle();
  endtask

  // Writeback every cycle fills the FIFO; the head starves until writeback backs off.
  task automatic test_fill_starve();
    do_reset();
    for (int c = 0; c < 15; c++) begin
      logic          wbe;
      logic          exp_ready;
      logic          exp_stall;
      logic          exp_we;
      logic [AW-1:0] exp_ad;
      logic [DW-1:0] exp_wd;
      int            exp_pend;
      wbe = (c < 10);
      drive(1'b0, wbe, 5'd3, 32'hA000_0000 + c, (c < 5), AW'(10 + c), 32'h100 + c);
      exp_ready = (c < 4);
      exp_stall = (c == 10);
      exp_pend  = (c < 4) ? c : (c <= 10 ? 4 : 14 - c);
      exp_we    = (c < 14);
      exp_ad    = wbe ? 5'd3 : AW'(c);
      exp_wd    = wbe ? 32'hA000_0000 + c : 32'h100 + (c - 10);
      @(negedge clk);
      if (c < 5) begin
        total++;
        if (sec.ready !== exp_ready) begin bad++; $display("FAIL fill_ready c=%0d got=%b exp=%b", c, sec.ready, exp_ready); end
      end
      total++;
      if (pending_cnt !== CW'(exp_pend)) begin bad++; $display("FAIL fill_pending c=%0d got=%0d exp=%0d", c, pending_cnt, exp_pend); end
      total++;
      if (stall_req !== exp_stall) begin bad++; $display("FAIL starve_stall c=%0d got=%b exp=%b", c, stall_req, exp_stall); end
      total++;
      if (we3 !== exp_we || (exp_we && (ad3 !== exp_ad || wd3 !== exp_wd))) begin
        bad++; $display("FAIL fill_port c=%0d got=%b/%0d/%h exp=%b/%0d/%h", c, we3, ad3, wd3, exp_we, exp_ad, exp_wd);
      end
      next_cycle();
    end
  endtask

  task automatic test_x0();
    do_reset();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd0, 32'h55);
    @(negedge clk);
    total++;
    if (sec.ready !== 1'b1 || we3 !== 1'b0) begin bad++; $display("FAIL x0_accept got=%b/%b exp=1/0", sec.ready, we3); end
    next_cycle();
    drive(1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd9, 32'h99);
    @(negedge clk);
    total++;
    if (pending_cnt !== '0) begin bad++; $display("FAIL x0_discard got=%0d exp=0", pending_cnt); end
    total++;
    if (we3 !== 1'b1 || ad3 !== 5'd3) begin bad++; $display("FAIL x0_wbprio got=%b/%0d exp=1/3", we3, ad3); end
    next_cycle();
    drive(1'b0, 1'b1, 5'd0, 32'h77, 1'b0, '0, '0);
    @(negedge clk);
    total++;
    if (we3 !== 1'b1 || ad3 !== 5'd9 || wd3 !== 32'h99) begin
      bad++; $display("FAIL x0_wb_idle got=%b/%0d/%h exp=1/9/99", we3, ad3, wd3);
    end
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    @(negedge clk);
    total++;
    if (pending_cnt !== '0 || we3 !== 1'b0) begin bad++; $display("FAIL x0_after got=%0d/%b exp=0/0", pending_cnt, we3); end
    next_cycle();
  endtask

`ifdef RF_WRITE_ARBITER_HAZARD_EN
  task automatic test_hazard();
    do_reset();
    rd_ad1 = 5'd7;
    rd_ad2 = 5'd0;
    drive(1'b0, 1'b1, 5'd3, 32'h1, 1'b1, 5'd7, 32'h7777);
    @(negedge clk);
    total++;
    if (hazard1 !== 1'b0) begin bad++; $display("FAIL haz_pre got=%b exp=0", hazard1); end
    next_cycle();
    drive(1'b0, 1'b1, 5'd3, 32'h2, 1'b0, '0, '0);
    @(negedge clk);
    total++;
    if (hazard1 !== 1'b1 || hazard2 !== 1'b0) begin bad++; $display("FAIL haz_hit got=%b/%b exp=1/0", hazard1, hazard2); end
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    next_cycle();
    @(negedge clk);
    total++;
    if (hazard1 !== 1'b0) begin bad++; $display("FAIL haz_cleared got=%b exp=0", hazard1); end
    next_cycle();
  endtask
`endif

  task automatic test_random();
    wr_req_t q[$];
    int      waited = 0;
    bit      stall_m = 1'b0;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic          r_rst, r_we, r_sv;
      logic [AW-1:0] r_wa, r_sa;
      logic [DW-1:0] r_wd, r_sd;
      logic          e_we, e_ready, e_stall;
      logic [AW-1:0] e_ad;
      logic [DW-1:0] e_wd;
      int            e_pend;
      bit            drained, was_empty, heavy;
      int            old_wait;
      heavy = ((cyc / 50) % 2) == 1;
      r_rst = ($urandom_range(0, 79) == 0);
      r_we  = stall_m ? 1'b0 : (heavy ? 1'b1 : 1'($urandom_range(0, 1)));
      r_wa  = ($urandom_range(0, 15) == 0) ? 5'd0 : AW'($urandom_range(1, 31));
      r_wd  = $urandom;
      r_sv  = 1'($urandom_range(0, 1));
      r_sa  = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom_range(1, 31));
      r_sd  = $urandom;
      drive(r_rst, r_we, r_wa, r_wd, r_sv, r_sa, r_sd);
`ifdef RF_WRITE_ARBITER_HAZARD_EN
      rd_ad1 = (q.size() > 0 && $urandom_range(0, 1) == 1) ? q[$urandom_range(0, q.size() - 1)].addr
                                                          : AW'($urandom_range(0, 31));
      rd_ad2 = AW'($urandom_range(0, 31));
`endif
      drained = 1'b0;
      e_we = 1'b0; e_ad = '0; e_wd = '0;
      e_ready = 1'b0; e_pend = 0; e_stall = 1'b0;
      if (!r_rst) begin
        e_ready = (q.size() < DEPTH);
        e_pend  = q.size();
        e_stall = stall_m;
        if (r_we && r_wa != 0) begin
          e_we = 1'b1; e_ad = r_wa; e_wd = r_wd;
        end else if (q.size() > 0) begin
          e_we = 1'b1; e_ad = q[0].addr; e_wd = q[0].data; drained = 1'b1;
        end
      end
      @(negedge clk);
      total++;
      if (we3 !== e_we || ((e_we || r_rst) && (ad3 !== e_ad || wd3 !== e_wd))) begin
        bad++; $display("FAIL rnd_port cyc=%0d got=%b/%0d/%h exp=%b/%0d/%h", cyc, we3, ad3, wd3, e_we, e_ad, e_wd);
      end
      total++;
      if (sec.ready !== e_ready) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, sec.ready, e_ready); end
      total++;
      if (pending_cnt !== CW'(e_pend)) begin bad++; $display("FAIL rnd_pending cyc=%0d got=%0d exp=%0d", cyc, pending_cnt, e_pend); end
      total++;
      if (stall_req !== e_stall) begin bad++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", cyc, stall_req, e_stall); end
`ifdef RF_WRITE_ARBITER_HAZARD_EN
      begin
        logic h1, h2;
        h1 = 1'b0; h2 = 1'b0;
        if (!r_rst) begin
          foreach (q[k]) begin
            if (rd_ad1 != 0 && q[k].addr == rd_ad1) h1 = 1'b1;
            if (rd_ad2 != 0 && q[k].addr == rd_ad2) h2 = 1'b1;
          end
        end
        total++;
        if (hazard1 !== h1 || hazard2 !== h2) begin
          bad++; $display("FAIL rnd_hazard cyc=%0d got=%b%b exp=%b%b", cyc, hazard1, hazard2, h1, h2);
        end
      end
`endif
      // Reference model update for the coming clock edge.
      if (r_rst) begin
        q.delete();
        waited  = 0;
        stall_m = 1'b0;
      end else begin
        was_empty = (q.size() == 0);
        old_wait  = waited;
        if (drained) void'(q.pop_front());
        if (r_sv && e_ready && r_sa != 0) q.push_back('{addr: r_sa, data: r_sd});
        waited = (was_empty || drained) ? 0 : ((waited < LIMIT) ? waited + 1 : LIMIT);
        if (drained) stall_m = 1'b0;
        else if (old_wait == LIMIT) stall_m = 1'b1;
      end
      next_cycle();
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
`ifdef RF_WRITE_ARBITER_HAZARD_EN
    rd_ad1 = '0;
    rd_ad2 = '0;
`endif
    next_cycle();
    test_reset();
    test_drain_latency();
    test_fill_starve();
    test_x0();
`ifdef RF_WRITE_ARBITER_HAZARD_EN
    test_hazard();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
